// File: rtl/counter_pkg.sv
// Shared sizing and types for the LUT-slice synchronous counter.
package counter_pkg;
  localparam int COUNT_WIDTH = 32;
  localparam int SLICE_WIDTH = 4;
  localparam int NUM_SLICES  = COUNT_WIDTH / SLICE_WIDTH;

  typedef logic [COUNT_WIDTH-1:0] count_t;
endpackage

// File: rtl/inc_lut_slice.sv
// Increment slice: sum = value + cin by table lookup, plus an all-ones flag for the carry chain.
// Latency: purely combinational. Backpressure: none.
module inc_lut_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] value,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             all_ones
);
  logic [SLICE-1:0] inc;

  assign all_ones = &value;
  assign sum      = cin ? inc : value;

  if (SLICE == 4) begin : g_lut
    always_comb begin
      inc = '0;
      case (value)
        4'h0: inc = 4'h1;
        4'h1: inc = 4'h2;
        4'h2: inc = 4'h3;
        4'h3: inc = 4'h4;
        4'h4: inc = 4'h5;
        4'h5: inc = 4'h6;
        4'h6: inc = 4'h7;
        4'h7: inc = 4'h8;
        4'h8: inc = 4'h9;
        4'h9: inc = 4'hA;
        4'hA: inc = 4'hB;
        4'hB: inc = 4'hC;
        4'hC: inc = 4'hD;
        4'hD: inc = 4'hE;
        4'hE: inc = 4'hF;
        4'hF: inc = 4'h0;
        default: inc = '0;
      endcase
    end
  end else begin : g_toggle
    // Other slice widths: bit i toggles when every lower bit of the slice is 1.
    always_comb begin
      logic run;
      inc = '0;
      run = 1'b1;
      for (int i = 0; i < SLICE; i++) begin
        inc[i] = value[i] ^ run;
        run    = run & value[i];
      end
    end
  end
endmodule

// File: rtl/syn_counter.sv
// Free-running synchronous up-counter built from increment-LUT slices with a lookahead carry.
// Latency: m_in combinational, count registers m_in one clock later. Backpressure: none.
module syn_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH = COUNT_WIDTH,
  parameter int               SLICE = SLICE_WIDTH,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] m_in
);
  localparam int NSL = WIDTH / SLICE;

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("syn_counter: WIDTH must be a multiple of SLICE");
  end

  logic [NSL-1:0] carry;
  logic [NSL-1:0] all_ones;
  logic           unused_top_ones;

  assign carry[0]        = 1'b1;
  // The top slice's flag would only feed a carry-out, which this counter discards.
  assign unused_top_ones = all_ones[NSL-1];

  for (genvar k = 0; k < NSL; k++) begin : g_slice
    inc_lut_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .value   (count[k*SLICE +: SLICE]),
      .cin     (carry[k]),
      .sum     (m_in[k*SLICE +: SLICE]),
      .all_ones(all_ones[k])
    );
    if (k > 0) begin : g_carry
      assign carry[k] = carry[k-1] & all_ones[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= INIT;
    end else begin
      count <= m_in;
    end
  end
endmodule

// File: tb/tb_syn_counter.sv
// Directed bench for syn_counter: reset, counting, slice carries, wrap, mid-run reset, long run.
module tb_syn_counter;
  import counter_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  count_t cnt_def, m_def, cnt_f, m_f, cnt_ff, m_ff, cnt_wr, m_wr, cnt_rn, m_rn;
  int     n_chk  = 0;
  int     n_fail = 0;

  always #5 clk = ~clk;

  syn_counter u_def (.clk(clk), .rst(rst), .count(cnt_def), .m_in(m_def));
  syn_counter #(.INIT(32'h0000_000F)) u_f  (.clk(clk), .rst(rst), .count(cnt_f),  .m_in(m_f));
  syn_counter #(.INIT(32'h00FF_FFFF)) u_ff (.clk(clk), .rst(rst), .count(cnt_ff), .m_in(m_ff));
  syn_counter #(.INIT(32'hFFFF_FFFE)) u_wr (.clk(clk), .rst(rst), .count(cnt_wr), .m_in(m_wr));
  syn_counter #(.INIT(32'hFFFF_F0A5)) u_rn (.clk(clk), .rst(rst), .count(cnt_rn), .m_in(m_rn));

  typedef struct {
    logic   rst_v;
    count_t e_def;
    count_t e_f;
    count_t e_ff;
    count_t e_wr;
    count_t em_wr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input count_t act, input count_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    count_t model;
    count_t prev_m;

    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_000F, 32'h00FF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_000F, 32'h00FF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'h0000_0001, 32'h0000_0010, 32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0002, 32'h0000_0011, 32'h0100_0001, 32'h0000_0000, 32'h0000_0001};
    vecs[4] = '{1'b0, 32'h0000_0003, 32'h0000_0012, 32'h0100_0002, 32'h0000_0001, 32'h0000_0002};
    vecs[5] = '{1'b0, 32'h0000_0004, 32'h0000_0013, 32'h0100_0003, 32'h0000_0002, 32'h0000_0003};

    // Reset applied from time 0, sampled before any clock edge.
    #1;
    chk("reset_count", cnt_def, 32'h0);
    chk("reset_m_in", m_def, 32'h1);

    for (int r = 0; r < 6; r++) begin
      rst = vecs[r].rst_v;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_def_count", r), cnt_def, vecs[r].e_def);
      chk($sformatf("vec%0d_def_m_in", r), m_def, vecs[r].e_def + 32'd1);
      chk($sformatf("vec%0d_f_count", r), cnt_f, vecs[r].e_f);
      chk($sformatf("vec%0d_f_m_in", r), m_f, vecs[r].e_f + 32'd1);
      chk($sformatf("vec%0d_ff_count", r), cnt_ff, vecs[r].e_ff);
      chk($sformatf("vec%0d_ff_m_in", r), m_ff, vecs[r].e_ff + 32'd1);
      chk($sformatf("vec%0d_wrap_count", r), cnt_wr, vecs[r].e_wr);
      chk($sformatf("vec%0d_wrap_m_in", r), m_wr, vecs[r].em_wr);
    end

    for (int n = 5; n <= 10; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("run_count_%0d", n), cnt_def, count_t'(n));
      chk($sformatf("run_m_in_%0d", n), m_def, count_t'(n + 1));
    end

    // Reset between edges must act without a clock edge.
    #1 rst = 1'b1;
    #1;
    chk("midreset_def_immediate", cnt_def, 32'h0);
    chk("midreset_wrap_immediate", cnt_wr, 32'hFFFF_FFFE);
    #2 rst = 1'b0;
    #1;
    chk("midreset_hold_until_edge", cnt_def, 32'h0);

    repeat (7) @(posedge clk);
    #1;
    chk("count_to_7", cnt_def, 32'h7);

    #1 rst = 1'b1;
    #1;
    chk("pulse_count_zero", cnt_def, 32'h0);
    chk("pulse_m_in_one", m_def, 32'h1);
    #2 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("resume_count_%0d", i), cnt_def, count_t'(i));
    end

    // Long run crossing the full-width carry and the wrap.
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    model = 32'hFFFF_F0A5;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      model = model + 32'd1;
      if (c > 0) chk($sformatf("long_follow_%0d", c), cnt_rn, prev_m);
      chk($sformatf("long_count_%0d", c), cnt_rn, model);
      chk($sformatf("long_m_in_%0d", c), m_rn, model + 32'd1);
      prev_m = m_rn;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
